// File: rtl/trace_pkg.sv
// Shared types and constants for the retire trace unit: record layout, kinds,
// serializer states and the header word layout.
package trace_pkg;

    localparam logic [1:0] KIND_REG   = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;
    localparam logic [1:0] KIND_BOTH  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_PC   = 3'd2;
    localparam logic [2:0] ST_ADDR = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;

    localparam int HDR_SEQ_LSB  = 24;
    localparam int HDR_KIND_LSB = 16;
    localparam int HDR_RD_LSB   = 0;

    localparam int REC_W = 8 + 2 + 5 + 96;

    typedef struct packed {
        logic [7:0]  seq;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    function automatic logic [31:0] hdr_word(input trace_rec_t r);
        logic [31:0] w;
        w = '0;
        w[HDR_SEQ_LSB +: 8]  = r.seq;
        w[HDR_KIND_LSB +: 2] = r.kind;
        w[HDR_RD_LSB +: 5]   = r.rd;
        return w;
    endfunction

endpackage

// File: rtl/retire_trace_unit_if.sv
// Retire-side inputs and the trace word stream of the retire trace unit.
// master = core/host side, slave = the trace unit.
interface retire_trace_if;
    logic        trace_en;
    logic [31:0] wb_pc;
    logic [31:0] wb_instruction;
    logic [31:0] wb_write_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_RegWrite;
    logic        wb_MemWrite;
    logic [31:0] wb_mem_addr;
    logic [31:0] wb_mem_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output trace_en, wb_pc, wb_instruction, wb_write_data, wb_rd_addr,
               wb_RegWrite, wb_MemWrite, wb_mem_addr, wb_mem_wdata, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  trace_en, wb_pc, wb_instruction, wb_write_data, wb_rd_addr,
               wb_RegWrite, wb_MemWrite, wb_mem_addr, wb_mem_wdata, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; a pop frees the slot a same-cycle push needs when full.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/retire_trace_unit.sv
// Captures WB-stage register writes and stores into a record FIFO and streams
// each record out as four 32-bit words (header, pc, addr, data).
module retire_trace_unit
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    retire_trace_if.slave          rt,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    logic [7:0]       seq_q;
    logic [2:0]       state_q;
    trace_rec_t       rec_in, cur_q;
    logic [REC_W-1:0] head_bits;
    logic             rd_write, ev, pop, full, empty, drop;
    logic             unused_instr;

    assign unused_instr = ^rt.wb_instruction;

    assign rd_write = rt.wb_RegWrite && (rt.wb_rd_addr != 5'd0);
    assign ev       = rt.trace_en && (rd_write || rt.wb_MemWrite);
    assign pop      = (state_q == ST_DATA) && rt.out_ready;
    assign drop     = ev && full && !pop;

    always_comb begin
        rec_in.seq  = seq_q;
        rec_in.kind = rt.wb_MemWrite ? (rd_write ? KIND_BOTH : KIND_STORE) : KIND_REG;
        rec_in.rd   = rt.wb_rd_addr;
        rec_in.pc   = rt.wb_pc;
        rec_in.addr = rt.wb_MemWrite ? rt.wb_mem_addr : 32'd0;
        rec_in.data = rt.wb_MemWrite ? rt.wb_mem_wdata : rt.wb_write_data;
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ev),
        .pop   (pop),
        .wdata (rec_in),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q      <= 8'd0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (ev) seq_q <= seq_q + 8'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // The head stays in the FIFO until its DATA word is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        cur_q   <= trace_rec_t'(head_bits);
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR:  if (rt.out_ready) state_q <= ST_PC;
                ST_PC:   if (rt.out_ready) state_q <= ST_ADDR;
                ST_ADDR: if (rt.out_ready) state_q <= ST_DATA;
                ST_DATA: if (rt.out_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rt.out_valid = (state_q != ST_IDLE);
        rt.out_last  = (state_q == ST_DATA);
        rt.out_data  = 32'd0;
        unique case (state_q)
            ST_HDR:  rt.out_data = hdr_word(cur_q);
            ST_PC:   rt.out_data = cur_q.pc;
            ST_ADDR: rt.out_data = cur_q.addr;
            ST_DATA: rt.out_data = cur_q.data;
            default: rt.out_data = 32'd0;
        endcase
    end
endmodule
